// File: rtl/cache_fill_arbiter.sv
// Line-fill arbiter: shares one memory read port between the I-cache (0) and D-cache (1) refills.
// Define CACHE_FILL_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module cache_fill_arbiter #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned MEM_LAT    = 3,
  localparam int unsigned IDX_W     = $clog2(LINE_WORDS)
) (
  input  logic              clk_100,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic [IDX_W-1:0]  rdata_idx,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [DATA_W-1:0] mem_data
);

  localparam int unsigned BASE_W = ADDR_W - IDX_W;
  localparam int unsigned CNT_W  = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t              r_state, w_state_nxt;
  logic [IDX_W-1:0]    r_word, w_word_nxt;
  logic [CNT_W-1:0]    r_wait_cnt, w_wait_nxt;
  logic                r_owner, w_owner_nxt;
  logic                r_last_owner, w_last_nxt;
  logic [BASE_W-1:0]   r_base, w_base_nxt;
  logic [1:0]          r_gnt, w_gnt_nxt;
  logic [1:0]          r_rvalid, w_rvalid_nxt;
  logic [1:0]          r_done, w_done_nxt;
  logic [DATA_W-1:0]   r_rdata, w_rdata_nxt;
  logic [IDX_W-1:0]    r_idx, w_idx_nxt;
  logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr_nxt;
  logic                r_rd_en, w_rd_en_nxt;

  logic                w_winner;
  logic [ADDR_W-1:0]   w_addr_sel;
  logic [BASE_W-1:0]   w_new_base;
  logic [IDX_W-1:0]    w_word_inc;

`ifdef CACHE_FILL_ARB_RR_EN
  // Contention goes to whichever side did not own the last line.
  assign w_winner = (req0 & req1) ? ~r_last_owner : req1;
`else
  assign w_winner = ~req0;
`endif

  assign w_addr_sel = w_winner ? addr1 : addr0;
  assign w_new_base = BASE_W'(w_addr_sel >> IDX_W);
  assign w_word_inc = IDX_W'(r_word + IDX_W'(1));

  always_ff @(posedge clk_100) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_word_nxt     = r_word;
    w_wait_nxt     = r_wait_cnt;
    w_owner_nxt    = r_owner;
    w_last_nxt     = r_last_owner;
    w_base_nxt     = r_base;
    w_gnt_nxt      = r_gnt;
    w_rvalid_nxt   = 2'b00;
    w_done_nxt     = 2'b00;
    w_rdata_nxt    = r_rdata;
    w_idx_nxt      = r_idx;
    w_mem_addr_nxt = r_mem_addr;
    w_rd_en_nxt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req0 | req1) begin
          w_state_nxt    = S_ISSUE;
          w_owner_nxt    = w_winner;
          w_base_nxt     = w_new_base;
          w_word_nxt     = '0;
          w_gnt_nxt      = w_winner ? 2'b10 : 2'b01;
          w_mem_addr_nxt = {w_new_base, {IDX_W{1'b0}}};
          w_rd_en_nxt    = 1'b1;
        end
      end
      S_ISSUE: begin
        w_state_nxt = S_WAIT;
        w_wait_nxt  = '0;
      end
      S_WAIT: begin
        // Capture edge: return the word, then either fetch the next one or finish.
        if (r_wait_cnt == CNT_W'(MEM_LAT - 1)) begin
          w_rdata_nxt  = mem_data;
          w_idx_nxt    = r_word;
          w_rvalid_nxt = r_owner ? 2'b10 : 2'b01;
          if (r_word == IDX_W'(LINE_WORDS - 1)) begin
            w_state_nxt = S_DONE;
            w_done_nxt  = r_owner ? 2'b10 : 2'b01;
          end else begin
            w_state_nxt    = S_ISSUE;
            w_word_nxt     = w_word_inc;
            w_mem_addr_nxt = {r_base, w_word_inc};
            w_rd_en_nxt    = 1'b1;
          end
        end else begin
          w_wait_nxt = CNT_W'(r_wait_cnt + CNT_W'(1));
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_gnt_nxt   = 2'b00;
        w_last_nxt  = r_owner;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_100) begin
    if (rst) begin
      r_word       <= '0;
      r_wait_cnt   <= '0;
      r_owner      <= 1'b0;
      r_last_owner <= 1'b1;
      r_base       <= '0;
      r_gnt        <= 2'b00;
      r_rvalid     <= 2'b00;
      r_done       <= 2'b00;
      r_rdata      <= '0;
      r_idx        <= '0;
      r_mem_addr   <= '0;
      r_rd_en      <= 1'b0;
    end else begin
      r_word       <= w_word_nxt;
      r_wait_cnt   <= w_wait_nxt;
      r_owner      <= w_owner_nxt;
      r_last_owner <= w_last_nxt;
      r_base       <= w_base_nxt;
      r_gnt        <= w_gnt_nxt;
      r_rvalid     <= w_rvalid_nxt;
      r_done       <= w_done_nxt;
      r_rdata      <= w_rdata_nxt;
      r_idx        <= w_idx_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_rd_en      <= w_rd_en_nxt;
    end
  end

  assign gnt0      = r_gnt[0];
  assign gnt1      = r_gnt[1];
  assign rvalid0   = r_rvalid[0];
  assign rvalid1   = r_rvalid[1];
  assign done0     = r_done[0];
  assign done1     = r_done[1];
  assign rdata     = r_rdata;
  assign rdata_idx = r_idx;
  assign mem_addr  = r_mem_addr;
  assign mem_rd_en = r_rd_en;

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Bench for cache_fill_arbiter: directed line fills plus random traffic against a
// transaction-timing model (cycle offset since accept decides every expected output).
module tb_cache_fill_arbiter;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned LW     = 4;
  localparam int unsigned LAT    = 3;
  localparam int unsigned IDX_W  = 2;
  localparam int PER = int'(LAT) + 1;
  localparam int N   = int'(LW) * PER;

  logic              clk_100 = 1'b0;
  logic              rst, req0, req1;
  logic [ADDR_W-1:0] addr0, addr1, mem_addr;
  logic [DATA_W-1:0] mem_data, rdata;
  logic [IDX_W-1:0]  rdata_idx;
  logic              gnt0, gnt1, rvalid0, rvalid1, done0, done1, mem_rd_en;

  always #5 clk_100 = ~clk_100;

  cache_fill_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_WORDS(LW), .MEM_LAT(LAT)
  ) dut (
    .clk_100(clk_100), .rst(rst), .req0(req0), .req1(req1),
    .addr0(addr0), .addr1(addr1), .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .done0(done0), .done1(done1),
    .rdata(rdata), .rdata_idx(rdata_idx), .mem_addr(mem_addr),
    .mem_rd_en(mem_rd_en), .mem_data(mem_data)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: who owns the port, its line base, and cycles since accept.
  bit                m_busy = 1'b0;
  bit                m_owner = 1'b0;
  bit                m_last = 1'b1;
  bit                m_rst = 1'b0;
  int                m_c = 0;
  logic [ADDR_W-1:0] m_base = '0;
  bit                hold0 = 1'b0;
  bit                hold1 = 1'b0;

  logic [ADDR_W-1:0] q_rd[$];
  bit                q_own[$];
  bit                prev_g0 = 1'b0;
  bit                prev_g1 = 1'b0;
  int t_rise0, t_rise1, t_done0, t_done1, n_rv0, n_done0, n_g0, n_g1;

  // Memory: data = addr ^ A5A5 valid only across the capture edge, garbage otherwise.
  int                mem_cnt = 0;
  logic [ADDR_W-1:0] mem_lat_addr = '0;
  always @(negedge clk_100) begin
    mem_data = DATA_W'($urandom);
    if (mem_cnt == 1) mem_data = mem_lat_addr ^ 16'hA5A5;
    if (mem_cnt > 0) mem_cnt--;
    if (mem_rd_en === 1'b1) begin
      mem_cnt      = int'(LAT);
      mem_lat_addr = mem_addr;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_edge();
    bit w;
    m_rst = rst;
    if (rst) begin
      m_busy = 1'b0;
      m_last = 1'b1;
      return;
    end
    if (m_busy) begin
      m_c++;
      if (m_c == N + 1) m_last = m_owner;
      if (m_c == N + 2) m_busy = 1'b0;
    end
    if (!m_busy && (req0 || req1)) begin
      if (req0 && req1) begin
`ifdef CACHE_FILL_ARB_RR_EN
        w = !m_last;
`else
        w = 1'b0;
`endif
      end else begin
        w = req1;
      end
      m_busy  = 1'b1;
      m_owner = w;
      m_c     = 0;
      m_base  = (w ? addr1 : addr0) & ~ADDR_W'(LW - 1);
    end
  endtask

  task automatic check_outputs();
    bit g, rv, d, rd;
    int k;
    logic [6:0] exp_ctl;
    g  = m_busy && m_c <= N;
    rv = m_busy && m_c >= PER && m_c <= N && (m_c % PER == 0);
    d  = m_busy && m_c == N;
    rd = m_busy && m_c < N && (m_c % PER == 0);
    exp_ctl = {g && !m_owner, g && m_owner, rv && !m_owner, rv && m_owner,
               d && !m_owner, d && m_owner, rd};
    check_eq("ctl{g0,g1,rv0,rv1,d0,d1,rd}",
             32'({gnt0, gnt1, rvalid0, rvalid1, done0, done1, mem_rd_en}), 32'(exp_ctl));
    if (rv) begin
      k = m_c / PER - 1;
      check_eq("rdata", 32'(rdata), 32'((m_base + ADDR_W'(k)) ^ 16'hA5A5));
      check_eq("rdata_idx", 32'(rdata_idx), 32'(k));
    end
    if (m_busy && m_c < N)
      check_eq("mem_addr", 32'(mem_addr), 32'(m_base + ADDR_W'(m_c / PER)));
    if (m_rst) begin
      check_eq("rst_rdata", 32'(rdata), 32'(0));
      check_eq("rst_idx", 32'(rdata_idx), 32'(0));
      check_eq("rst_mem_addr", 32'(mem_addr), 32'(0));
    end
    cyc++;
    if (mem_rd_en) q_rd.push_back(mem_addr);
    if (gnt0 && !prev_g0) begin q_own.push_back(1'b0); t_rise0 = cyc; end
    if (gnt1 && !prev_g1) begin q_own.push_back(1'b1); t_rise1 = cyc; end
    if (done0) begin t_done0 = cyc; n_done0++; end
    if (done1) t_done1 = cyc;
    if (rvalid0) n_rv0++;
    if (gnt0) n_g0++;
    if (gnt1) n_g1++;
    prev_g0 = gnt0;
    prev_g1 = gnt1;
  endtask

  task automatic cycle();
    @(posedge clk_100);
    model_edge();
    @(negedge clk_100);
    check_outputs();
  endtask

  task automatic drop_on_done();
    if (m_busy && m_c == N) begin
      if (m_owner && !hold1) req1 = 1'b0;
      if (!m_owner && !hold0) req0 = 1'b0;
    end
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      cycle();
      drop_on_done();
      if (!m_busy && !req0 && !req1) return;
    end
    check_eq("timeout", 32'(1), 32'(0));
  endtask

  task automatic clear_obs();
    q_rd.delete();
    q_own.delete();
    t_rise0 = 0; t_rise1 = 0; t_done0 = 0; t_done1 = 0;
    n_rv0 = 0; n_done0 = 0; n_g0 = 0; n_g1 = 0;
  endtask

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0; mem_data = '0;
    clear_obs();
    repeat (3) cycle();
    rst = 1'b0;
    cycle();

    // Single request from the I-cache.
    clear_obs();
    addr0 = 16'h1234; req0 = 1'b1;
    wait_idle(100);
    check_eq("t1_nreads", 32'(q_rd.size()), 32'(LW));
    if (q_rd.size() == LW)
      for (int i = 0; i < int'(LW); i++) check_eq("t1_addr", 32'(q_rd[i]), 32'(16'h1234 + i));
    check_eq("t1_done_lat", 32'(t_done0 - t_rise0), 32'(N));
    check_eq("t1_gnt1_idle", 32'(n_g1), 32'(0));

    // Single request from the D-cache with unaligned address.
    clear_obs();
    addr1 = 16'h00F3; req1 = 1'b1;
    wait_idle(100);
    check_eq("t2_nreads", 32'(q_rd.size()), 32'(LW));
    if (q_rd.size() == LW)
      for (int i = 0; i < int'(LW); i++) check_eq("t2_addr", 32'(q_rd[i]), 32'(16'h00F0 + i));
    check_eq("t2_done_lat", 32'(t_done1 - t_rise1), 32'(N));
    check_eq("t2_gnt0_idle", 32'(n_g0), 32'(0));

    // Simultaneous requests, each dropped on its done.
    clear_obs();
    addr0 = ADDR_W'($urandom); addr1 = ADDR_W'($urandom); req0 = 1'b1; req1 = 1'b1;
    wait_idle(200);
    check_eq("t3_nlines", 32'(q_own.size()), 32'(2));
    if (q_own.size() == 2) begin
      check_eq("t3_first", 32'(q_own[0]), 32'(0));
      check_eq("t3_second", 32'(q_own[1]), 32'(1));
    end
    check_eq("t3_gap", 32'(t_rise1 - t_rise0), 32'(N + 2));

    // Both held continuously for four lines.
    clear_obs();
    hold0 = 1'b1; hold1 = 1'b1; req0 = 1'b1; req1 = 1'b1;
    repeat (4 * (N + 2)) cycle();
    hold0 = 1'b0; hold1 = 1'b0; req0 = 1'b0; req1 = 1'b0;
    wait_idle(100);
    check_eq("t4_nlines", 32'(q_own.size()), 32'(4));
    if (q_own.size() == 4)
      for (int i = 0; i < 4; i++)
`ifdef CACHE_FILL_ARB_RR_EN
        check_eq("t4_owner", 32'(q_own[i]), 32'(i % 2));
`else
        check_eq("t4_owner", 32'(q_own[i]), 32'(0));
`endif

    // Reset nine cycles into a line; request stays high and restarts.
    clear_obs();
    addr0 = ADDR_W'($urandom); req0 = 1'b1;
    repeat (9) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    wait_idle(100);
    check_eq("t5_done_cnt", 32'(n_done0), 32'(1));
    check_eq("t5_rv_cnt", 32'(n_rv0), 32'((9 - 1) / PER + int'(LW)));

    // Request dropped mid-line still completes.
    clear_obs();
    addr0 = ADDR_W'($urandom); req0 = 1'b1;
    repeat (5) cycle();
    req0 = 1'b0;
    wait_idle(100);
    check_eq("t6_rv_cnt", 32'(n_rv0), 32'(LW));
    check_eq("t6_done_cnt", 32'(n_done0), 32'(1));

    // Random traffic, address churn, mid-line drops and occasional reset.
    for (int i = 0; i < 3000; i++) begin
      cycle();
      rst = 1'b0;
      if (m_busy && m_c == N && ($urandom % 4 != 0)) begin
        if (m_owner) req1 = 1'b0;
        else         req0 = 1'b0;
      end
      if (!req0 && ($urandom % 6 == 0)) begin req0 = 1'b1; addr0 = ADDR_W'($urandom); end
      else if (req0 && ($urandom % 60 == 0)) req0 = 1'b0;
      if (!req1 && ($urandom % 6 == 0)) begin req1 = 1'b1; addr1 = ADDR_W'($urandom); end
      else if (req1 && ($urandom % 60 == 0)) req1 = 1'b0;
      if ($urandom % 4 == 0) addr0 = ADDR_W'($urandom);
      if ($urandom % 4 == 0) addr1 = ADDR_W'($urandom);
      if ($urandom % 250 == 0) rst = 1'b1;
    end
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
    wait_idle(100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
